// File: rtl/sseg_capture.sv
`default_nettype none
// ============================================================================
// Module : sseg_capture
// Desc   : Decodes a multiplexed active-low 7-segment bus back into a 16-bit
//          value, published after repeated identical complete scans.
// Rev    : 1.0  initial release
// ============================================================================
module sseg_capture #(
  parameter int SETTLE        = 4,
  parameter int CONFIRM_SCANS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  digit_ok,
  output logic        valid,
  output logic        err
);

  localparam int c_cnt_w   = $clog2(SETTLE);
  localparam int c_match_w = $clog2(CONFIRM_SCANS + 1);

  typedef enum logic [0:0] {ST_SETTLING = 1'b0, ST_HELD = 1'b1} state_t;

  state_t               r_state;
  logic [6:0]           r_seg_s1, r_seg_s2;
  logic [3:0]           r_an_s1, r_an_s2;
  logic [10:0]          r_prev;
  logic [c_cnt_w-1:0]   r_stab_cnt;
  logic [15:0]          r_nibs;
  logic [3:0]           r_oks;
  logic [3:0]           r_seen;
  logic [19:0]          r_last_scan;
  logic [c_match_w-1:0] r_match;
  logic                 r_published;

  logic [10:0]          w_cur;
  logic                 w_same, w_settled, w_single, w_capture, w_multi;
  logic                 w_complete, w_publish, w_ok;
  logic [3:0]           w_low, w_nib, w_seen_next, w_oks_next;
  logic [1:0]           w_idx;
  logic [15:0]          w_nibs_next;
  logic [19:0]          w_scan;
  logic [c_match_w-1:0] w_match_next;

  always_comb begin
    w_ok = 1'b1;
    case (r_seg_s2)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      default: begin
        w_nib = 4'h0;
        w_ok  = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_cur     = {r_an_s2, r_seg_s2};
    w_same    = (w_cur == r_prev);
    // A change on the threshold cycle clears w_same, so it wins over capture.
    w_settled = (r_state == ST_SETTLING) && w_same &&
                (r_stab_cnt == c_cnt_w'(SETTLE - 2));
    w_low     = ~r_an_s2;
    w_single  = (w_low != 4'd0) && ((w_low & (w_low - 4'd1)) == 4'd0);
    w_capture = w_settled && w_single;
    w_multi   = w_settled && !w_single && (w_low != 4'd0);

    case (w_low)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase

    w_nibs_next = r_nibs;
    w_oks_next  = r_oks;
    w_seen_next = r_seen;
    if (w_capture) begin
      w_nibs_next[{w_idx, 2'b00} +: 4] = w_nib;
      w_oks_next[w_idx]                = w_ok;
      w_seen_next                      = r_seen | w_low;
    end
    w_complete = w_capture && (w_seen_next == 4'hF);
    w_scan     = {w_nibs_next, w_oks_next};

    if (w_scan == r_last_scan)
      w_match_next = (r_match == c_match_w'(CONFIRM_SCANS)) ? r_match : r_match + 1'b1;
    else
      w_match_next = c_match_w'(1);

    w_publish = w_complete && (w_match_next == c_match_w'(CONFIRM_SCANS)) &&
                (!r_published || (w_scan != {value, digit_ok}));
  end

  // Synchronizer and previous-sample registers idle at the bus's inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1    <= 7'h7F;
      r_seg_s2    <= 7'h7F;
      r_an_s1     <= 4'hF;
      r_an_s2     <= 4'hF;
      r_prev      <= 11'h7FF;
      r_state     <= ST_SETTLING;
      r_stab_cnt  <= '0;
      r_nibs      <= '0;
      r_oks       <= '0;
      r_seen      <= '0;
      r_last_scan <= '0;
      r_match     <= '0;
      r_published <= 1'b0;
      value       <= '0;
      digit_ok    <= '0;
      valid       <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_seg_s1 <= seg;
      r_seg_s2 <= r_seg_s1;
      r_an_s1  <= an;
      r_an_s2  <= r_an_s1;
      r_prev   <= w_cur;
      valid    <= w_publish;
      err      <= w_multi;

      case (r_state)
        ST_SETTLING: begin
          if (!w_same)
            r_stab_cnt <= '0;
          else if (w_settled)
            r_state <= ST_HELD;
          else
            r_stab_cnt <= r_stab_cnt + 1'b1;
        end
        default: begin
          if (!w_same) begin
            r_state    <= ST_SETTLING;
            r_stab_cnt <= '0;
          end
        end
      endcase

      r_nibs <= w_nibs_next;
      r_oks  <= w_oks_next;
      r_seen <= w_complete ? 4'h0 : w_seen_next;
      if (w_complete) begin
        r_last_scan <= w_scan;
        r_match     <= w_match_next;
      end
      if (w_publish) begin
        value       <= w_nibs_next;
        digit_ok    <= w_oks_next;
        r_published <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
